// File: rtl/delta_sigma_bg_ctrl.sv
// delta_sigma_bg_ctrl
// Per-pixel background tracker for a fixed-size frame stream. Each accepted
// pixel reads its background word from an external pipelined memory and moves
// it one step toward the pixel value; pixels far from the background are
// flagged as foreground. The first frame after reset or bg_reinit seeds the
// memory with the raw pixels instead.

module delta_sigma_bg_ctrl #(
    parameter int  PIX_WIDTH_p    = 8,
    parameter int  FRAME_PIXELS_p = 16,
    parameter int  RD_LATENCY_p   = 3,
    parameter int  THRESH_p       = 20,
    localparam int ADDRWIDTH_c    = $clog2(FRAME_PIXELS_p)
) (
    input  logic                   clk_drv,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   bg_reinit,
    input  logic                   pix_valid,
    input  logic                   pix_sof,
    input  logic [PIX_WIDTH_p-1:0] pix_data,
    output logic                   mem_wrena,
    output logic [ADDRWIDTH_c-1:0] mem_wraddr,
    output logic [PIX_WIDTH_p-1:0] mem_wrdata,
    output logic [ADDRWIDTH_c-1:0] mem_rdaddr,
    input  logic [PIX_WIDTH_p-1:0] mem_rddata,
    output logic                   fg_valid,
    output logic                   fg_mask,
    output logic [PIX_WIDTH_p-1:0] fg_bg,
    output logic                   frame_done,
    output logic                   sof_err
);

    localparam logic [ADDRWIDTH_c-1:0] LAST_ADDR_c = ADDRWIDTH_c'(FRAME_PIXELS_p - 1);
    localparam logic [PIX_WIDTH_p:0]   THRESH_c    = (PIX_WIDTH_p + 1)'(THRESH_p);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        INIT     = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [ADDRWIDTH_c-1:0] cnt_reg, cnt_next;
    logic                   reinit_reg, reinit_next;
    logic                   sof_err_reg, sof_err_next;

    // Accept-cycle decode results
    logic                   accept;
    logic [ADDRWIDTH_c-1:0] acc_addr;
    logic                   acc_init;
    logic                   reinit_eff;

    // Output registers
    logic                   fg_valid_reg;
    logic                   fg_mask_reg;
    logic [PIX_WIDTH_p-1:0] fg_bg_reg;
    logic [ADDRWIDTH_c-1:0] wraddr_reg;
    logic                   frame_done_reg;

    // Tail of the alignment pipeline, lined up with mem_rddata
    logic                   tail_valid;
    logic                   tail_init;
    logic [ADDRWIDTH_c-1:0] tail_addr;
    logic [PIX_WIDTH_p-1:0] tail_pix;

    // Update datapath
    logic [PIX_WIDTH_p:0]   pix_ext;
    logic [PIX_WIDTH_p:0]   bg_ext;
    logic [PIX_WIDTH_p:0]   abs_diff;
    logic [PIX_WIDTH_p-1:0] new_bg;
    logic                   new_mask;

    // Frame state, pixel counter, reinit flag and sof_err decode
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        reinit_next  = reinit_reg;
        sof_err_next = 1'b0;
        accept       = 1'b0;
        acc_addr     = '0;
        acc_init     = 1'b0;
        // A reinit request arriving with an SOF applies to that SOF
        reinit_eff   = reinit_reg | (enable & bg_reinit);

        if (enable && bg_reinit) begin
            reinit_next = 1'b1;
        end

        if (enable && pix_valid) begin
            case (state_reg)
                WAIT_SOF: begin
                    if (pix_sof) begin
                        accept      = 1'b1;
                        acc_init    = 1'b1;
                        state_next  = INIT;
                        reinit_next = 1'b0;
                    end
                end
                default: begin
                    if (pix_sof) begin
                        // SOF always restarts at pixel 0; a restart mid-frame is an error
                        accept       = 1'b1;
                        sof_err_next = (cnt_reg != '0);
                        if (reinit_eff) begin
                            reinit_next = 1'b0;
                            state_next  = INIT;
                            acc_init    = 1'b1;
                        end else begin
                            acc_init = (state_reg == INIT);
                        end
                    end else if (cnt_reg == '0) begin
                        // Missing SOF: drop the pixel
                        sof_err_next = 1'b1;
                    end else begin
                        accept   = 1'b1;
                        acc_addr = cnt_reg;
                        acc_init = (state_reg == INIT);
                    end
                end
            endcase
        end

        if (accept) begin
            if (acc_addr == LAST_ADDR_c) begin
                cnt_next = '0;
                if (state_next == INIT) begin
                    state_next = RUN;
                end
            end else begin
                cnt_next = acc_addr + ADDRWIDTH_c'(1);
            end
        end
    end

    assign mem_rdaddr = acc_addr;

    // Control state registers, frozen while enable is low
    always_ff @(posedge clk_drv) begin
        if (reset) begin
            state_reg   <= WAIT_SOF;
            cnt_reg     <= '0;
            reinit_reg  <= 1'b0;
            sof_err_reg <= 1'b0;
        end else if (enable) begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            reinit_reg  <= reinit_next;
            sof_err_reg <= sof_err_next;
        end
    end

    // Delay line carrying pixel, address, valid and mode alongside the memory read
    genvar gi;
    generate
        for (gi = 0; gi < RD_LATENCY_p; gi++) begin : g_pipe
            logic                   in_valid;
            logic                   in_init;
            logic [ADDRWIDTH_c-1:0] in_addr;
            logic [PIX_WIDTH_p-1:0] in_pix;
            logic                   valid_reg;
            logic                   init_reg;
            logic [ADDRWIDTH_c-1:0] addr_reg;
            logic [PIX_WIDTH_p-1:0] pix_reg;

            if (gi == 0) begin : g_first
                assign in_valid = accept;
                assign in_init  = acc_init;
                assign in_addr  = acc_addr;
                assign in_pix   = pix_data;
            end else begin : g_next
                assign in_valid = g_pipe[gi-1].valid_reg;
                assign in_init  = g_pipe[gi-1].init_reg;
                assign in_addr  = g_pipe[gi-1].addr_reg;
                assign in_pix   = g_pipe[gi-1].pix_reg;
            end

            // One enabled-cycle delay stage
            always_ff @(posedge clk_drv) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    init_reg  <= 1'b0;
                    addr_reg  <= '0;
                    pix_reg   <= '0;
                end else if (enable) begin
                    valid_reg <= in_valid;
                    init_reg  <= in_init;
                    addr_reg  <= in_addr;
                    pix_reg   <= in_pix;
                end
            end
        end
    endgenerate

    assign tail_valid = g_pipe[RD_LATENCY_p-1].valid_reg;
    assign tail_init  = g_pipe[RD_LATENCY_p-1].init_reg;
    assign tail_addr  = g_pipe[RD_LATENCY_p-1].addr_reg;
    assign tail_pix   = g_pipe[RD_LATENCY_p-1].pix_reg;

    // Background step and foreground decision; steps never cross the range ends
    always_comb begin
        pix_ext  = {1'b0, tail_pix};
        bg_ext   = {1'b0, mem_rddata};
        abs_diff = (pix_ext >= bg_ext) ? (pix_ext - bg_ext) : (bg_ext - pix_ext);
        new_bg   = mem_rddata;
        new_mask = 1'b0;
        if (tail_init) begin
            new_bg = tail_pix;
        end else begin
            if (mem_rddata < tail_pix) begin
                new_bg = mem_rddata + PIX_WIDTH_p'(1);
            end else if (mem_rddata > tail_pix) begin
                new_bg = mem_rddata - PIX_WIDTH_p'(1);
            end
            new_mask = (abs_diff > THRESH_c);
        end
    end

    // Registered results and write-back
    always_ff @(posedge clk_drv) begin
        if (reset) begin
            fg_valid_reg   <= 1'b0;
            fg_mask_reg    <= 1'b0;
            fg_bg_reg      <= '0;
            wraddr_reg     <= '0;
            frame_done_reg <= 1'b0;
        end else if (enable) begin
            fg_valid_reg   <= tail_valid;
            fg_mask_reg    <= tail_valid & new_mask;
            fg_bg_reg      <= tail_valid ? new_bg : '0;
            wraddr_reg     <= tail_valid ? tail_addr : '0;
            frame_done_reg <= tail_valid && (tail_addr == LAST_ADDR_c);
        end
    end

    assign fg_valid   = fg_valid_reg;
    assign fg_mask    = fg_mask_reg;
    assign fg_bg      = fg_bg_reg;
    assign mem_wrena  = fg_valid_reg;
    assign mem_wraddr = wraddr_reg;
    assign mem_wrdata = fg_bg_reg;
    assign frame_done = frame_done_reg;
    assign sof_err    = sof_err_reg;

endmodule

// File: doc/delta_sigma_bg_ctrl.md
DELTA_SIGMA_BG_CTRL -- requirements
Module: delta_sigma_bg_ctrl

Interface
REQ-001 Parameter PIX_WIDTH_p, default 8, pixel width and background word width.
REQ-002 Parameter FRAME_PIXELS_p, default 16, pixels per frame and number of background memory words; SHALL be >= 2*(RD_LATENCY_p+1).
REQ-003 Parameter RD_LATENCY_p, default 3, enabled cycles from mem_rdaddr presentation to valid mem_rddata; the default matches the background memory with input and output registers both enabled.
REQ-004 Parameter THRESH_p, default 20, foreground threshold on |pixel - background|.
REQ-005 Localparam ADDRWIDTH_c SHALL be ceil(log2(FRAME_PIXELS_p)).
REQ-006 Port clk_drv, input, 1, sole clock, rising edge.
REQ-007 Port reset, input, 1, synchronous active-high reset.
REQ-008 Port enable, input, 1, global clock enable shared with the memory; low freezes all state.
REQ-009 Port bg_reinit, input, 1, pulse: next frame is re-initialised.
REQ-010 Ports pix_valid (1), pix_sof (1), pix_data (PIX_WIDTH_p), inputs, pixel stream; pix_sof marks pixel 0.
REQ-011 Ports mem_wrena (1), mem_wraddr (ADDRWIDTH_c), mem_wrdata (PIX_WIDTH_p), outputs, memory write port.
REQ-012 Port mem_rdaddr, output, ADDRWIDTH_c, memory read address; port mem_rddata, input, PIX_WIDTH_p, memory read data.
REQ-013 Ports fg_valid (1), fg_mask (1), fg_bg (PIX_WIDTH_p), outputs, per-pixel result and the updated background value.
REQ-014 Ports frame_done (1) and sof_err (1), outputs, single-cycle pulses.

Function
REQ-015 Only cycles with enable=1 SHALL count; with enable=0 all registers and pulse outputs SHALL hold their values.
REQ-016 FSM states SHALL be WAIT_SOF, INIT and RUN.
REQ-017 WAIT_SOF SHALL drop pixels without pix_sof; pix_valid&pix_sof SHALL accept pixel 0 and enter INIT.
REQ-018 A pixel is accepted when enable&pix_valid in INIT/RUN or on the entering SOF; the pixel counter (0..FRAME_PIXELS_p-1) SHALL then advance and wrap to 0 after the last pixel.
REQ-019 mem_rdaddr SHALL equal the current pixel counter combinationally in the accept cycle.
REQ-020 Pixel, address, valid and frame-mode SHALL be delayed RD_LATENCY_p enabled cycles to align with mem_rddata.
REQ-021 In INIT the new background SHALL be pix_data and fg_mask SHALL be 0; mem_rddata SHALL be ignored.
REQ-022 In RUN the new background SHALL be bg+1 if bg<pix, bg-1 if bg>pix, else bg, where bg=mem_rddata; saturation at 0 and 2^PIX_WIDTH_p-1 SHALL hold.
REQ-023 In RUN fg_mask SHALL be 1 iff |pix - bg| > THRESH_p, with bg the value read before the update and the difference computed at PIX_WIDTH_p+1 bits.
REQ-024 Results SHALL be registered: the pixel accepted at enabled cycle T SHALL produce fg_valid=1, fg_mask, fg_bg=new background, mem_wrena=1, mem_wraddr=its address and mem_wrdata=fg_bg at T+RD_LATENCY_p+1.
REQ-025 mem_wrena and fg_valid SHALL be 0 in every cycle without a result.
REQ-026 frame_done SHALL pulse together with fg_valid of pixel FRAME_PIXELS_p-1.
REQ-027 The state SHALL change INIT->RUN when pixel FRAME_PIXELS_p-1 is accepted.
REQ-028 In INIT/RUN, a pixel at counter 0 without pix_sof SHALL be dropped with sof_err pulsed the next cycle.
REQ-029 In INIT/RUN, pix_sof at counter!=0 SHALL pulse sof_err, restart the counter at 0 with this pixel accepted, and keep the current state; already-issued pipeline results SHALL complete.
REQ-030 bg_reinit SHALL set a sticky flag; the next accepted SOF SHALL clear the flag and enter INIT.
REQ-031 mem_rdaddr SHALL be 0 when no pixel is accepted.

Reset
REQ-032 reset=1 at a clock edge SHALL override enable and set the state to WAIT_SOF, clear the counter, the pipeline valid bits and the reinit flag, and drive all registered outputs to 0.
REQ-033 Reset mid-frame SHALL discard in-flight results with no write issued; the following frame SHALL start with INIT.

Verification
REQ-034 After reset, a 16-pixel frame of value 100 with SOF -> 16 writes of 100 to addresses 0..15, fg_mask=0, frame_done on the 16th, latency 4 cycles.
REQ-035 A second frame of 110 -> writes of 101 and fg_mask=0; a third frame of 130 (bg 101, diff 29>20) -> fg_mask=1, write 102.
REQ-036 With bg=255 and pixel 255, and with bg=0 and pixel 0 -> writes unchanged, with no wrap.
REQ-037 pix_sof at pixel 5 -> sof_err pulses, the counter restarts, and that pixel writes address 0; pixel without SOF at counter 0 -> dropped and sof_err pulses.
REQ-038 enable held low 3 cycles mid-frame -> outputs frozen; results resume in order with no lost or duplicated writes.
REQ-039 bg_reinit during a RUN frame -> the next frame behaves as INIT (writes equal pixels, fg_mask=0).
